// File: rtl/psram_async_ctrl.sv
// Asynchronous-mode CellularRAM (PSRAM) controller with a single-outstanding req/ready port.
// Every output is registered; timing is set by the RD_WAIT, WR_WAIT and RECOVERY parameters.
module psram_async_ctrl #(
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RD_WAIT  = 4,
  parameter int unsigned WR_WAIT  = 3,
  parameter int unsigned RECOVERY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        be,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              wdone,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [DATA_W-1:0] mem_dq_i,
  output logic [DATA_W-1:0] mem_dq_o,
  output logic              mem_dq_oe,
  output logic              ram_cs_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              ram_ub_n,
  output logic              ram_lb_n,
  output logic              mem_adv_n,
  output logic              ram_cre,
  output logic              mem_clk
);

  typedef enum logic [2:0] {StIdle, StRdAcc, StWrAcc, StWrHold, StRecover} stateT;

  stateT             stateQ, stateD;
  logic [5:0]        cntQ, cntD;
  logic              readyQ, readyD, rvalidQ, rvalidD, wdoneQ, wdoneD;
  logic [DATA_W-1:0] rdataQ, rdataD, dqOQ, dqOD;
  logic [ADDR_W-1:0] adrQ, adrD;
  logic              dqOeQ, dqOeD, csNQ, csND, oeNQ, oeND, weNQ, weND, ubNQ, ubND, lbNQ, lbND;

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    readyD  = readyQ;
    rvalidD = 1'b0;
    wdoneD  = 1'b0;
    rdataD  = rdataQ;
    adrD    = adrQ;
    dqOD    = dqOQ;
    dqOeD   = dqOeQ;
    csND    = csNQ;
    oeND    = oeNQ;
    weND    = weNQ;
    ubND    = ubNQ;
    lbND    = lbNQ;
    case (stateQ)
      StIdle: begin
        if (req) begin
          readyD = 1'b0;
          if (be == 2'b00) begin
            // No lanes enabled: complete without touching the bus, one extra recovery cycle
            stateD  = StRecover;
            cntD    = 6'(RECOVERY);
            rvalidD = ~we;
            wdoneD  = we;
            if (!we) rdataD = '0;
          end else begin
            adrD = addr;
            csND = 1'b0;
            ubND = ~be[1];
            lbND = ~be[0];
            if (we) begin
              stateD = StWrAcc;
              cntD   = 6'(WR_WAIT - 1);
              weND   = 1'b0;
              dqOeD  = 1'b1;
              dqOD   = wdata;
            end else begin
              stateD = StRdAcc;
              cntD   = 6'(RD_WAIT - 1);
              oeND   = 1'b0;
            end
          end
        end
      end
      StRdAcc: begin
        if (cntQ == 6'd0) begin
          rdataD  = mem_dq_i & {{8{~ubNQ}}, {8{~lbNQ}}};
          rvalidD = 1'b1;
          csND    = 1'b1;
          oeND    = 1'b1;
          ubND    = 1'b1;
          lbND    = 1'b1;
          stateD  = StRecover;
          cntD    = 6'(RECOVERY - 1);
        end else begin
          cntD = cntQ - 6'd1;
        end
      end
      StWrAcc: begin
        if (cntQ == 6'd0) begin
          weND   = 1'b1;
          stateD = StWrHold;
        end else begin
          cntD = cntQ - 6'd1;
        end
      end
      StWrHold: begin
        // WE_n already high; chip select, strobes and data were held one cycle for hold time
        csND   = 1'b1;
        ubND   = 1'b1;
        lbND   = 1'b1;
        dqOeD  = 1'b0;
        wdoneD = 1'b1;
        stateD = StRecover;
        cntD   = 6'(RECOVERY - 1);
      end
      StRecover: begin
        if (cntQ == 6'd0) begin
          stateD = StIdle;
          readyD = 1'b1;
        end else begin
          cntD = cntQ - 6'd1;
        end
      end
      default: begin
        stateD = StIdle;
        readyD = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      readyQ  <= 1'b1;
      rvalidQ <= 1'b0;
      wdoneQ  <= 1'b0;
      rdataQ  <= '0;
      adrQ    <= '0;
      dqOQ    <= '0;
      dqOeQ   <= 1'b0;
      csNQ    <= 1'b1;
      oeNQ    <= 1'b1;
      weNQ    <= 1'b1;
      ubNQ    <= 1'b1;
      lbNQ    <= 1'b1;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      readyQ  <= readyD;
      rvalidQ <= rvalidD;
      wdoneQ  <= wdoneD;
      rdataQ  <= rdataD;
      adrQ    <= adrD;
      dqOQ    <= dqOD;
      dqOeQ   <= dqOeD;
      csNQ    <= csND;
      oeNQ    <= oeND;
      weNQ    <= weND;
      ubNQ    <= ubND;
      lbNQ    <= lbND;
    end
  end

  assign ready     = readyQ;
  assign rvalid    = rvalidQ;
  assign wdone     = wdoneQ;
  assign rdata     = rdataQ;
  assign mem_adr   = adrQ;
  assign mem_dq_o  = dqOQ;
  assign mem_dq_oe = dqOeQ;
  assign ram_cs_n  = csNQ;
  assign mem_oe_n  = oeNQ;
  assign mem_we_n  = weNQ;
  assign ram_ub_n  = ubNQ;
  assign ram_lb_n  = lbNQ;
  assign mem_adv_n = 1'b0;
  assign ram_cre   = 1'b0;
  assign mem_clk   = 1'b0;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Bench for psram_async_ctrl: pin-level PSRAM model plus a per-cycle expected-timeline model.
module tb_psram_async_ctrl;

  localparam int RW = 4;
  localparam int WW = 3;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = '0;
  logic        ready, rvalid, wdone;
  logic [15:0] rdata;
  logic [22:0] mem_adr;
  logic [15:0] mem_dq_i = '0;
  logic [15:0] mem_dq_o;
  logic        mem_dq_oe, ram_cs_n, mem_oe_n, mem_we_n, ram_ub_n, ram_lb_n;
  logic        mem_adv_n, ram_cre, mem_clk;

  int total = 0;
  int bad = 0;
  logic [15:0] expRdata = '0;
  logic [15:0] psram [logic [22:0]];
  logic [15:0] refMem [logic [22:0]];
  logic [22:0] addrTab [6];

  psram_async_ctrl #(
    .ADDR_W(23), .DATA_W(16), .RD_WAIT(RW), .WR_WAIT(WW), .RECOVERY(RC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .wdone(wdone), .mem_adr(mem_adr),
    .mem_dq_i(mem_dq_i), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe), .ram_cs_n(ram_cs_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n),
    .mem_adv_n(mem_adv_n), .ram_cre(ram_cre), .mem_clk(mem_clk)
  );

  always #5 clk = ~clk;

  // Pin-level PSRAM: writes land while CS_n and WE_n are low; read bus follows the address.
  always @(negedge clk) begin
    logic [15:0] w;
    if (!ram_cs_n && !mem_we_n) begin
      w = psram.exists(mem_adr) ? psram[mem_adr] : 16'h0;
      if (!ram_ub_n) w[15:8] = mem_dq_o[15:8];
      if (!ram_lb_n) w[7:0] = mem_dq_o[7:0];
      psram[mem_adr] = w;
    end
    mem_dq_i = psram.exists(mem_adr) ? psram[mem_adr] : 16'h0;
  end

  // Issue one request at the current negedge (ready expected) and check every cycle until ready.
  task automatic run_txn(input logic w, input logic [22:0] a, input logic [15:0] d,
                         input logic [1:0] b, input bit keep);
    logic [15:0] cur, mask, newRd, nw;
    logic [8:0]  expV, actV;
    bit          inAcc;
    int          endK;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready: got %b want 1", ready);
    end
    mask  = {{8{b[1]}}, {8{b[0]}}};
    cur   = refMem.exists(a) ? refMem[a] : 16'h0;
    newRd = cur & mask;
    if (w && b != 2'b00) begin
      nw = (cur & ~mask) | (d & mask);
      refMem[a] = nw;
    end
    endK = (b == 2'b00) ? RC + 2 : (w ? WW + RC + 2 : RW + RC + 1);
    we = w; addr = a; wdata = d; be = b; req = 1'b1;
    @(posedge clk);
    #1 if (!keep) req = 1'b0;
    for (int k = 1; k <= endK; k++) begin
      @(negedge clk);
      if (w) begin
        inAcc = (b != 2'b00) && (k <= WW + 1);
        expV = {!inAcc, 1'b1, !((b != 2'b00) && (k <= WW)), !(inAcc && b[1]),
                !(inAcc && b[0]), inAcc, 1'b0,
                (b == 2'b00) ? (k == 1) : (k == WW + 2), k == endK};
      end else begin
        inAcc = (b != 2'b00) && (k <= RW);
        expV = {!inAcc, !inAcc, 1'b1, !(inAcc && b[1]), !(inAcc && b[0]), 1'b0,
                (b == 2'b00) ? (k == 1) : (k == RW + 1), 1'b0, k == endK};
        if (k >= ((b == 2'b00) ? 1 : RW + 1)) expRdata = newRd;
      end
      actV = {ram_cs_n, mem_oe_n, mem_we_n, ram_ub_n, ram_lb_n, mem_dq_oe, rvalid, wdone, ready};
      total++;
      if (actV !== expV) begin
        bad++;
        $display("FAIL pins we=%b be=%b k=%0d: got %b want %b (cs oe we ub lb dqoe rv wd rdy)",
                 w, b, k, actV, expV);
      end
      total++;
      if (rdata !== expRdata) begin
        bad++;
        $display("FAIL rdata we=%b be=%b k=%0d: got %h want %h", w, b, k, rdata, expRdata);
      end
      if (inAcc) begin
        total++;
        if (mem_adr !== a) begin
          bad++;
          $display("FAIL mem_adr k=%0d: got %h want %h", k, mem_adr, a);
        end
        if (w) begin
          total++;
          if (mem_dq_o !== d) begin
            bad++;
            $display("FAIL mem_dq_o k=%0d: got %h want %h", k, mem_dq_o, d);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({ready, ram_cs_n, mem_oe_n, mem_we_n, ram_ub_n, ram_lb_n, mem_dq_oe, rvalid, wdone,
         mem_adv_n, ram_cre, mem_clk} !== 12'b111111000000) begin
      bad++;
      $display("FAIL reset_pins: got %b want 111111000000",
               {ready, ram_cs_n, mem_oe_n, mem_we_n, ram_ub_n, ram_lb_n, mem_dq_oe, rvalid,
                wdone, mem_adv_n, ram_cre, mem_clk});
    end
    total++;
    if ({rdata, mem_adr, mem_dq_o} !== 55'h0) begin
      bad++;
      $display("FAIL reset_regs: got rdata=%h adr=%h dq_o=%h want 0", rdata, mem_adr, mem_dq_o);
    end
  endtask

  task automatic test_write_default;
    run_txn(1'b1, 23'h000123, 16'hBEEF, 2'b11, 1'b0);
  endtask

  task automatic test_read;
    run_txn(1'b0, 23'h000123, 16'h0, 2'b11, 1'b0);
    run_txn(1'b0, 23'h000123, 16'h0, 2'b01, 1'b0);
    run_txn(1'b0, 23'h000123, 16'h0, 2'b10, 1'b0);
  endtask

  task automatic test_be_zero;
    run_txn(1'b1, 23'h000123, 16'h1234, 2'b00, 1'b0);
    run_txn(1'b0, 23'h000123, 16'h0, 2'b00, 1'b0);
    run_txn(1'b0, 23'h000123, 16'h0, 2'b11, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 23'h400001, 16'hA55A, 2'b11, 1'b1);
    run_txn(1'b0, 23'h400001, 16'h0, 2'b11, 1'b1);
    run_txn(1'b1, 23'h400001, 16'h0FF0, 2'b10, 1'b1);
    run_txn(1'b0, 23'h400001, 16'h0, 2'b11, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), addrTab[$urandom_range(0, 5)], 16'($urandom),
              2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid;
    we = 1'b1; addr = 23'h7ABCD; wdata = 16'hC0DE; be = 2'b11; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({ram_cs_n, mem_we_n, mem_dq_oe, ready} !== 4'b1101) begin
      bad++;
      $display("FAIL reset_mid_pins: got %b want 1101 (cs we dqoe rdy)",
               {ram_cs_n, mem_we_n, mem_dq_oe, ready});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({wdone, rvalid} !== 2'b00) begin
        bad++;
        $display("FAIL reset_mid_pulse k=%0d: got %b want 00", k, {wdone, rvalid});
      end
    end
    rst = 1'b0;
    expRdata = 16'h0;
    @(negedge clk);
    total++;
    if ({wdone, ready, ram_cs_n} !== 3'b011) begin
      bad++;
      $display("FAIL reset_mid_release: got %b want 011 (wd rdy cs)", {wdone, ready, ram_cs_n});
    end
    run_txn(1'b0, 23'h400001, 16'h0, 2'b11, 1'b0);
  endtask

  initial begin
    addrTab[0] = 23'h000123; addrTab[1] = 23'h400001; addrTab[2] = 23'h000000;
    addrTab[3] = 23'h7FFFFF; addrTab[4] = 23'h2AAAAA; addrTab[5] = 23'h155555;
    test_reset();
    test_write_default();
    test_read();
    test_be_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
